// File: rtl/x74595.sv
// x74595: serial-in, parallel-out shift register with a separate output
// storage register, modelled on a 74x595. Bits shift into sr one per cycle.
// A latch copies sr into st in a single edge, so downstream logic never sees
// a partially loaded word.
//
// Optional feature macro: X74595_AUTOLATCH_EN
//   When defined, the shift that completes a full word also latches it.
//   That shift stores the post-shift value and clears the counter, so full
//   never reads high. latch_en still works for early or partial latches.
module x74595 #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ser,
    input  logic             shift_en,
    input  logic             latch_en,
    input  logic             oe_n,
    output logic [WIDTH-1:0] q,
    output logic             qh_ser,
    output logic             full,
    inout  wire              _vss,
    inout  wire              _vdd
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(WIDTH);

    logic [WIDTH-1:0] sr;
    logic [WIDTH-1:0] st;
    logic [CW-1:0]    cnt;

    logic [WIDTH-1:0] sr_next;
    logic [CW-1:0]    cnt_next;
    logic             auto_latch;
    logic             do_latch;

    // The power pins carry no logic. They are gathered here only so that
    // they are visibly accounted for.
    wire unused_power = _vss ^ _vdd;

    // Next-state decode: the post-shift word, the saturating count and the
    // latch decision, which also covers the auto-latch case.
    always_comb begin
        // NOTE: every signal gets a default before any branch, so no path
        // leaves a signal unassigned and no latch is inferred.
        sr_next    = sr;
        cnt_next   = cnt;
        auto_latch = 1'b0;

        if (shift_en) begin
            sr_next = {sr[WIDTH-2:0], ser};
            if (cnt != CNT_MAX) begin
                cnt_next = cnt + 1'b1;
            end
        end

`ifdef X74595_AUTOLATCH_EN
        // The shift that would make the count reach WIDTH latches the word.
        auto_latch = shift_en && (cnt == CNT_MAX - 1'b1);
`endif

        do_latch = latch_en | auto_latch;

        // A latch stores the post-shift word and restarts the count.
        if (do_latch) begin
            cnt_next = '0;
        end
    end

    // State registers. Reset clears all state at once and discards any
    // partially shifted word.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments only. Each
        // register then samples the pre-edge value of the others, which
        // matches the hardware.
        if (!rst_n) begin
            sr  <= '0;
            st  <= '0;
            cnt <= '0;
        end else begin
            sr  <= sr_next;
            cnt <= cnt_next;
            if (do_latch) begin
                st <= sr_next;
            end
        end
    end

    // Outputs. The output enable gates only the pins and never touches st.
    // full is decoded from the registered count.
    always_comb begin
        q      = oe_n ? '0 : st;
        qh_ser = sr[WIDTH-1];
        full   = (cnt == CNT_MAX);
    end

endmodule

// File: tb/tb_x74595.sv
// Self-checking bench for x74595. The reference model tracks the shift
// register, the storage register and the number of bits shifted since the
// last latch as plain integers. Outputs are sampled 1 time unit after each
// rising edge.
module tb_x74595;

    localparam int W    = 8;
    localparam int MASK = (1 << W) - 1;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         ser;
    logic         shift_en;
    logic         latch_en;
    logic         oe_n;
    logic [W-1:0] q;
    logic         qh_ser;
    logic         full;
    wire          vss = 1'b0;
    wire          vdd = 1'b1;

    int n_vec = 0;
    int n_err = 0;

    // Reference state
    int m_sr  = 0;
    int m_st  = 0;
    int m_cnt = 0;

    x74595 #(.WIDTH(W)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .ser      (ser),
        .shift_en (shift_en),
        .latch_en (latch_en),
        .oe_n     (oe_n),
        .q        (q),
        .qh_ser   (qh_ser),
        .full     (full),
        ._vss     (vss),
        ._vdd     (vdd)
    );

    always #5 clk = ~clk;

    // Apply one rising edge to the model.
    function automatic void model_edge(input logic s, input logic sh, input logic la);
        logic auto_l;
        auto_l = 1'b0;
        if (sh) m_sr = ((m_sr << 1) | int'(s)) & MASK;
`ifdef X74595_AUTOLATCH_EN
        auto_l = sh && (m_cnt + 1 == W);
`endif
        if (la || auto_l) begin
            m_st  = m_sr;
            m_cnt = 0;
        end else if (sh && m_cnt < W) begin
            m_cnt = m_cnt + 1;
        end
    endfunction

    function automatic void model_reset();
        m_sr  = 0;
        m_st  = 0;
        m_cnt = 0;
    endfunction

    // Expected {q, qh_ser, full} for the current model state and oe_n.
    function automatic logic [W+1:0] exp_out();
        logic [W-1:0] eq;
        eq = oe_n ? '0 : W'(m_st);
        return {eq, 1'((m_sr >> (W - 1)) & 1), 1'(m_cnt == W)};
    endfunction

    // x7408 outputs {Y4,Y3,Y2,Y1} for a given q: Y(k+1) = q[2k] & q[2k+1].
    function automatic logic [3:0] and_gates(input logic [W-1:0] v);
        return {v[7] & v[6], v[5] & v[4], v[3] & v[2], v[1] & v[0]};
    endfunction

    // Drive one cycle of stimulus, then sample 1 time unit after the edge.
    task automatic step(input logic s, input logic sh, input logic la);
        ser      = s;
        shift_en = sh;
        latch_en = la;
        @(posedge clk);
        model_edge(s, sh, la);
        #1;
        shift_en = 1'b0;
        latch_en = 1'b0;
    endtask

    // Pulse reset between edges and release it before the next edge.
    task automatic pulse_reset();
        rst_n = 1'b0;
        model_reset();
        #2;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; ser = 1'b1; shift_en = 1'b1; latch_en = 1'b1; oe_n = 1'b0;
        #3;
        n_vec++;
        if ({q, qh_ser, full} !== '0) begin
            n_err++;
            $display("FAIL reset_async: got q=%h qh=%b full=%b, want all 0", q, qh_ser, full);
        end
        @(posedge clk);
        #1;
        n_vec++;
        if ({q, qh_ser, full} !== '0) begin
            n_err++;
            $display("FAIL reset_held: got q=%h qh=%b full=%b, want all 0", q, qh_ser, full);
        end
        shift_en = 1'b0; latch_en = 1'b0;
        rst_n = 1'b1;
        model_reset();
        step(1'b0, 1'b0, 1'b0);
        n_vec++;
        if ({q, qh_ser, full} !== exp_out()) begin
            n_err++;
            $display("FAIL reset_idle: got %b, want %b", {q, qh_ser, full}, exp_out());
        end
    endtask

    task automatic test_load_pattern();
        logic [W-1:0] pat;
        pat = 8'b1011_0010;
        pulse_reset();
        for (int i = W - 1; i >= 0; i--) begin
            step(pat[i], 1'b1, 1'b0);
            n_vec++;
            if ({q, qh_ser, full} !== exp_out()) begin
                n_err++;
                $display("FAIL load_shift%0d: got %b, want %b", i, {q, qh_ser, full}, exp_out());
            end
        end
`ifndef X74595_AUTOLATCH_EN
        n_vec++;
        if (full !== 1'b1 || q !== 8'h00) begin
            n_err++;
            $display("FAIL load_before_latch: got full=%b q=%h, want full=1 q=00", full, q);
        end
`endif
        step(1'b0, 1'b0, 1'b1);
        n_vec++;
        if (q !== 8'hB2 || full !== 1'b0) begin
            n_err++;
            $display("FAIL load_latched: got q=%h full=%b, want q=b2 full=0", q, full);
        end
        // 0xB2 pairs: only q[5:4] are both high, so only Y3 is high.
        n_vec++;
        if (and_gates(q) !== and_gates(W'(m_st)) || and_gates(q) !== 4'b0100) begin
            n_err++;
            $display("FAIL load_and_gates: got Y4..Y1=%b, want 0100", and_gates(q));
        end
    endtask

    task automatic test_output_enable();
        oe_n = 1'b1;
        #1;
        n_vec++;
        if (q !== 8'h00) begin
            n_err++;
            $display("FAIL oe_off: got q=%h, want 00", q);
        end
        oe_n = 1'b0;
        #1;
        n_vec++;
        if (q !== 8'hB2) begin
            n_err++;
            $display("FAIL oe_on: got q=%h, want b2", q);
        end
        step(1'b0, 1'b0, 1'b0);
        n_vec++;
        if ({q, qh_ser, full} !== exp_out()) begin
            n_err++;
            $display("FAIL oe_no_state_change: got %b, want %b", {q, qh_ser, full}, exp_out());
        end
    endtask

    task automatic test_hold();
        for (int i = 0; i < W + 2; i++) begin
            step(1'b1, 1'b1, 1'b0);
            n_vec++;
            if ({q, qh_ser, full} !== exp_out()) begin
                n_err++;
                $display("FAIL hold_shift%0d: got %b, want %b", i, {q, qh_ser, full}, exp_out());
            end
        end
`ifndef X74595_AUTOLATCH_EN
        n_vec++;
        if (q !== 8'hB2 || qh_ser !== 1'b1 || full !== 1'b1) begin
            n_err++;
            $display("FAIL hold_saturate: got q=%h qh=%b full=%b, want b2 1 1", q, qh_ser, full);
        end
`endif
    endtask

    task automatic test_back_to_back();
        logic [6:0] pre;
        pre = 7'b1111000;
        for (int i = 6; i >= 0; i--) step(pre[i], 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b1);
        n_vec++;
        if (q !== 8'hF1 || full !== 1'b0) begin
            n_err++;
            $display("FAIL simul_shift_latch: got q=%h full=%b, want f1 0", q, full);
        end
        n_vec++;
        if ({q, qh_ser, full} !== exp_out()) begin
            n_err++;
            $display("FAIL simul_model: got %b, want %b", {q, qh_ser, full}, exp_out());
        end
    endtask

    task automatic test_reset_midload();
        logic [W-1:0] pat;
        pat = 8'h5A;
        for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 1'b0);
        rst_n = 1'b0;
        model_reset();
        #2;
        n_vec++;
        if ({q, qh_ser, full} !== '0) begin
            n_err++;
            $display("FAIL midload_async_clear: got q=%h qh=%b full=%b, want all 0", q, qh_ser, full);
        end
        rst_n = 1'b1;
        for (int i = W - 1; i >= 0; i--) step(pat[i], 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b1);
        n_vec++;
        if (q !== 8'h5A) begin
            n_err++;
            $display("FAIL midload_reload: got q=%h, want 5a", q);
        end
    endtask

`ifdef X74595_AUTOLATCH_EN
    task automatic test_autolatch();
        logic [W-1:0] pat;
        pat = 8'h3C;
        pulse_reset();
        for (int i = W - 1; i >= 0; i--) begin
            step(pat[i], 1'b1, 1'b0);
            n_vec++;
            if (full !== 1'b0) begin
                n_err++;
                $display("FAIL autolatch_full_bit%0d: got full=%b, want 0", i, full);
            end
        end
        n_vec++;
        if (q !== 8'h3C) begin
            n_err++;
            $display("FAIL autolatch_q: got q=%h, want 3c", q);
        end
    endtask
`endif

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 59) == 0) pulse_reset();
            oe_n = ($urandom_range(0, 6) == 0);
            #1;
            n_vec++;
            if ({q, qh_ser, full} !== exp_out()) begin
                n_err++;
                $display("FAIL rand_pre%0d: got %b, want %b", i, {q, qh_ser, full}, exp_out());
            end
            step(1'($urandom), $urandom_range(0, 9) < 7, $urandom_range(0, 9) == 0);
            n_vec++;
            if ({q, qh_ser, full} !== exp_out()) begin
                n_err++;
                $display("FAIL rand_edge%0d: got %b, want %b", i, {q, qh_ser, full}, exp_out());
            end
        end
        oe_n = 1'b0;
    endtask

    initial begin
        test_reset();
        test_load_pattern();
        test_output_enable();
        test_hold();
        test_back_to_back();
        test_reset_midload();
`ifdef X74595_AUTOLATCH_EN
        test_autolatch();
`endif
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
